// File: rtl/psub_seq.sv
// psub_seq: sequential packed sub-word saturating subtractor.
// Computes a - b one signed LANE_W-bit lane per clock and latches the result
// under valid/ready handshakes on both sides.
// Optional build macro PSUB_WRAP_EN: overflowed lanes keep the wrapped
// difference instead of saturating; sat_flags still reports the overflow.
module psub_seq #(
   parameter int LANE_W = 4,
   parameter int LANES  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANE_W*LANES-1:0]   a,
   input  logic [LANE_W*LANES-1:0]   b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANE_W*LANES-1:0]   res,
   output logic [LANES-1:0]          sat_flags
);

   localparam int DW = LANE_W * LANES;
   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [DW-1:0]     a_reg;
   logic [DW-1:0]     b_reg;
   logic [DW-1:0]     res_reg;
   logic [LANES-1:0]  sat_reg;
   logic              in_ready_reg;
   logic              out_valid_reg;

   // Per-lane result candidates, all lanes evaluated in parallel; the FSM
   // commits only the lane selected by the counter on each BUSY edge.
   logic [LANE_W-1:0] lane_val [LANES];
   logic [LANES-1:0]  lane_ovf;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [LANE_W-1:0] a_k;
         logic [LANE_W-1:0] b_k;
         logic [LANE_W-1:0] d_k;

         assign a_k = a_reg[gi*LANE_W +: LANE_W];
         assign b_k = b_reg[gi*LANE_W +: LANE_W];
         assign d_k = a_k - b_k;

         // Overflow only possible when operand signs differ and the
         // difference's sign disagrees with the minuend.
         assign lane_ovf[gi] = (a_k[LANE_W-1] != b_k[LANE_W-1]) &&
                               (d_k[LANE_W-1] != a_k[LANE_W-1]);
`ifdef PSUB_WRAP_EN
         assign lane_val[gi] = d_k;
`else
         logic [LANE_W-1:0] sat_k;
         // Clamp toward the minuend's sign: negative -> 100..0, positive -> 011..1.
         assign sat_k = {a_k[LANE_W-1], {(LANE_W-1){~a_k[LANE_W-1]}}};
         assign lane_val[gi] = lane_ovf[gi] ? sat_k : d_k;
`endif
      end
   endgenerate

   // Control FSM: capture operands, step one lane per edge, hold result until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         res_reg       <= '0;
         sat_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg        <= a;
                  b_reg        <= b;
                  res_reg      <= '0;
                  sat_reg      <= '0;
                  cnt_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= BUSY;
               end
            end
            BUSY: begin
               for (int i = 0; i < LANES; i++) begin
                  if (cnt_reg == CW'(i)) begin
                     res_reg[i*LANE_W +: LANE_W] <= lane_val[i];
                     sat_reg[i]                  <= lane_ovf[i];
                  end
               end
               if (cnt_reg == CW'(LANES - 1)) begin
                  cnt_reg       <= '0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               cnt_reg       <= '0;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign res       = res_reg;
   assign sat_flags = sat_reg;

endmodule

// File: tb/tb_psub_seq.sv
// tb_psub_seq: directed bench for psub_seq with a transaction-level model
// (whole-word signed arithmetic per lane) checked every cycle.
module tb_psub_seq;

   localparam int LANE_W = 4;
   localparam int LANES  = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] res;
   logic [3:0]  sat_flags;

   int pass_cnt  = 0;
   int total_cnt = 0;

   psub_seq #(.LANE_W(LANE_W), .LANES(LANES)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .sat_flags(sat_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total_cnt++;
      if (got !== want)
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      else
         pass_cnt++;
   endtask

   // Reference: {flags, result} from plain signed integer subtraction per lane.
   function automatic logic [19:0] ref_sub(input logic [15:0] av, input logic [15:0] bv);
      logic [15:0] r;
      logic [3:0]  f;
      int sa, sb, df;
      r = '0;
      f = '0;
      for (int i = 0; i < LANES; i++) begin
         sa = $signed(av[i*4 +: 4]);
         sb = $signed(bv[i*4 +: 4]);
         df = sa - sb;
         f[i] = (df > 7) || (df < -8);
`ifdef PSUB_WRAP_EN
         r[i*4 +: 4] = df[3:0];
`else
         if (df > 7)       r[i*4 +: 4] = 4'h7;
         else if (df < -8) r[i*4 +: 4] = 4'h8;
         else              r[i*4 +: 4] = df[3:0];
`endif
      end
      return {f, r};
   endfunction

   // Model: 0 idle, 1 busy (counting LANES edges), 2 holding a result.
   int          m_state;
   int          m_cnt;
   logic [15:0] m_res;
   logic [3:0]  m_flags;
   logic [15:0] m_a;
   logic [15:0] m_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state <= 0;
         m_cnt   <= 0;
      end else begin
         case (m_state)
            0: if (in_valid) begin
                  {m_flags, m_res} <= ref_sub(a, b);
                  m_a     <= a;
                  m_b     <= b;
                  m_cnt   <= 1;
                  m_state <= 1;
               end
            1: if (m_cnt == LANES) m_state <= 2;
               else m_cnt <= m_cnt + 1;
            default: if (out_ready) begin
                  $display("txn a=%h b=%h res=%h flags=%h", m_a, m_b, res, sat_flags);
                  m_state <= 0;
               end
         endcase
      end
   end

   // Per-cycle comparison of handshake and result outputs against the model.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_res", {16'd0, res}, 32'd0);
         chk("rst_flags", {28'd0, sat_flags}, 32'd0);
      end else begin
         chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_state == 0});
         chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_state == 2});
         if (m_state == 2) begin
            chk("cyc_res", {16'd0, res}, {16'd0, m_res});
            chk("cyc_flags", {28'd0, sat_flags}, {28'd0, m_flags});
         end
      end
   end

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Called at posedge+1 with the unit idle; leaves it idle again if out_ready=1.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic [3:0] ef, input string nm);
      int n;
      in_valid = 1'b1;
      a = av;
      b = bv;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      wait_out(n);
      chk({nm, "_latency"}, n, 4);
      chk({nm, "_res"}, {16'd0, res}, {16'd0, er});
      chk({nm, "_flags"}, {28'd0, sat_flags}, {28'd0, ef});
      if (out_ready) begin
         @(posedge clk); #1;
         chk({nm, "_back_idle"}, {31'd0, in_ready}, 32'd1);
      end
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_res", {16'd0, res}, 32'd0);
      @(posedge clk); #1;

      // Basic, overflow, mixed lanes and boundary lanes
      run_op(16'h1234, 16'h1111, 16'h0123, 4'h0, "basic");
`ifdef PSUB_WRAP_EN
      run_op(16'h7777, 16'h8888, 16'hFFFF, 4'hF, "pos_ovf");
      run_op(16'h8000, 16'h1000, 16'h7000, 4'h8, "mix_neg");
      run_op(16'h0F00, 16'h8000, 16'h8F00, 4'h8, "mix_pos");
      run_op(16'h0000, 16'h8888, 16'h8888, 4'hF, "zero_minus_min");
`else
      run_op(16'h7777, 16'h8888, 16'h7777, 4'hF, "pos_ovf");
      run_op(16'h8000, 16'h1000, 16'h8000, 4'h8, "mix_neg");
      run_op(16'h0F00, 16'h8000, 16'h7F00, 4'h8, "mix_pos");
      run_op(16'h0000, 16'h8888, 16'h7777, 4'hF, "zero_minus_min");
`endif
      run_op(16'h8888, 16'h8888, 16'h0000, 4'h0, "min_minus_min");

      // Backpressure: result must hold and new operands must be refused
      out_ready = 1'b0;
      run_op(16'h7654, 16'h1234, 16'h6420, 4'h0, "bp");
      in_valid = 1'b1;
      a = 16'h1111;
      b = 16'h2222;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_res", {16'd0, res}, 32'h6420);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_release_res_kept", {16'd0, res}, 32'h6420);

      // Reset mid-operation after two BUSY edges
      in_valid = 1'b1;
      a = 16'h1234;
      b = 16'h1111;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_partial_res", {16'd0, res}, 32'h0023);
      rst = 1'b1;
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_res", {16'd0, res}, 32'd0);
      chk("abort_flags", {28'd0, sat_flags}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(16'h5555, 16'h1111, 16'h4444, 4'h0, "after_abort");

      // Back-to-back with in_valid held high
      in_valid = 1'b1;
      a = 16'h0000;
      b = 16'h8888;
      @(posedge clk); #1;
      a = 16'h8888;
      b = 16'h8888;
      wait_out(n);
      chk("b2b_first_latency", n, 4);
`ifdef PSUB_WRAP_EN
      chk("b2b_first_res", {16'd0, res}, 32'h8888);
`else
      chk("b2b_first_res", {16'd0, res}, 32'h7777);
`endif
      chk("b2b_first_flags", {28'd0, sat_flags}, 32'hF);
      @(posedge clk); #1;
      chk("b2b_gap_out_valid", {31'd0, out_valid}, 32'd0);
      chk("b2b_gap_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
      wait_out(n);
      chk("b2b_second_latency", n, 4);
      chk("b2b_second_res", {16'd0, res}, 32'h0000);
      chk("b2b_second_flags", {28'd0, sat_flags}, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/psub_seq.md
Name: psub_seq

Overview:
- Sequential parallel sub-word saturating subtractor: the subtract counterpart to the packed-nibble saturating adder in the execute stage.
- Computes A − B independently per signed sub-word lane, one lane per clock, and saturates lanes that overflow.
- Serves the packed-subtract path of the ALU.
- Uses valid/ready handshakes on both sides so the multicycle unit can stall the pipeline.

Parameters:
- LANE_W, 4, width in bits of one signed sub-word lane.
- LANES, 4, number of lanes. Data width DW = LANE_W*LANES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept operands.
- a  input  DW  packed minuend.
- b  input  DW  packed subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- res  output  DW  packed result; lane i at bits [i*LANE_W +: LANE_W].
- sat_flags  output  LANES  bit i set if lane i overflowed.

Behaviour:
- Reset (async, rst=1): state IDLE, lane counter 0, res=0, sat_flags=0, out_valid=0. in_ready=1 once rst deasserts.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture a and b into operand registers, clear res and sat_flags, set counter=0, go to BUSY.
  - in_valid=0 leaves the unit idle.
- State BUSY:
  - in_ready=0, out_valid=0.
  - Each edge processes lane k=counter:
    - d = a_k − b_k, computed in two's complement, LANE_W bits.
    - ovf = (a_k msb ≠ b_k msb) && (d msb ≠ a_k msb).
    - res lane k gets the saturated value if ovf, else d. Saturated value: a_k msb=1 gives most-negative (1 followed by zeros, 0x8 for 4-bit); a_k msb=0 gives most-positive (0 followed by ones, 0x7).
    - sat_flags[k] = ovf.
  - After lane LANES−1 is processed: go to DONE, counter wraps to 0.
- State DONE:
  - out_valid=1, in_ready=0.
  - res and sat_flags are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE. res and sat_flags keep their values until the next capture.
- Latency: operands accepted at edge T → out_valid observed high after edge T+LANES (4 cycles at default).
  - Throughput: one operation per LANES+2 cycles with out_ready tied high.
- Handshake rules:
  - a and b are sampled only on the accepting edge; later changes on a and b are ignored.
  - in_valid and in_ready are never both high outside IDLE.
  - out_valid, once high, does not drop until accepted.
- Boundary conditions:
  - Lane A=−8, B=−8 gives 0, no overflow.
  - Lane A=0, B=−8 gives 8, which overflows → 0x7.
  - rst asserted in BUSY or DONE aborts the operation immediately; the partial result is discarded and outputs return to reset values.
  - out_ready while not in DONE is ignored.

Optional Feature:
- Macro: PSUB_WRAP_EN.
- Defined: saturation disabled. Overflowed lanes write the raw wrapped difference d. sat_flags still reports overflow per lane. Timing unchanged.
- Undefined: saturating behaviour as specified above.

Test Plan:
1. Basic subtract: a=0x1234, b=0x1111, out_ready=1 → after 4 cycles out_valid=1, res=0x0123, sat_flags=0x0.
2. Positive overflow: a=0x7777, b=0x8888 → res=0x7777, sat_flags=0xF. With PSUB_WRAP_EN: res=0xFFFF, sat_flags=0xF.
3. Mixed lanes:
   - a=0x8000, b=0x1000 → res=0x8000, sat_flags=0x8 (top lane −8−1 saturates to 0x8).
   - a=0x0F00, b=0x8000 → res=0x7F00, sat_flags=0x8 (top lane 0−(−8) saturates to 0x7).
4. Backpressure: hold out_ready=0 for 3 cycles after out_valid → res and out_valid stable, in_ready=0, new in_valid not accepted. Raise out_ready → IDLE next edge, in_ready=1.
5. Reset mid-operation: start a=0x1234, b=0x1111; assert rst after 2 BUSY edges → out_valid=0, res=0, sat_flags=0 immediately. Deassert rst, issue a=0x5555, b=0x1111 → res=0x4444.
6. Back-to-back: in_valid held high with two operand pairs, out_ready=1 → second pair accepted on the edge after the first result handshake. Both results correct, no overlap of out_valid.
